// File: rtl/ofm_pack_save_if.sv
// Beat-in / bank-write-out bundle for the OFM packer.
// The master side is the producer/testbench and the slave side is the packer.
interface ofm_pack_save_if #(
    parameter int DW    = 32,
    parameter int PACK  = 4,
    parameter int NBANK = 16,
    parameter int AW    = 10
);
    logic                 i_start;
    logic [AW-1:0]        i_base;
    logic                 i_vld;
    logic [DW-1:0]        i_data;
    logic                 i_last;
    logic                 o_rdy;
    logic [DW*PACK-1:0]   o_wdata;
    logic [AW-1:0]        o_addr;
    logic [NBANK-1:0]     o_cs;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_err;

    modport master (
        output i_start, i_base, i_vld, i_data, i_last,
        input  o_rdy, o_wdata, o_addr, o_cs, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_base, i_vld, i_data, i_last,
        output o_rdy, o_wdata, o_addr, o_cs, o_busy, o_done, o_err
    );
endinterface

// File: rtl/ofm_pack_save.sv
// Packs PACK DW-bit OFM beats into one word and writes it round-robin across
// NBANK IFM banks; the shared address steps after each full bank sweep.
module ofm_pack_save #(
    parameter int DW    = 32,
    parameter int PACK  = 4,
    parameter int NBANK = 16,
    parameter int AW    = 10
) (
    input  logic           clk,
    input  logic           rstn,
    ofm_pack_save_if.slave bus
);
    localparam int LW = $clog2(PACK);
    localparam int BW = $clog2(NBANK);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic [DW*PACK-1:0]  pack_q, pack_d;
    logic [DW*PACK-1:0]  wdata_q, wdata_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [BW-1:0]       bank_q, bank_d;
    logic [NBANK-1:0]    cs_q, cs_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                full_q, full_d;

    logic                accept;
    logic                complete;
    logic [DW*PACK-1:0]  merged;

    assign accept   = bus.i_vld && (state_q == ST_RUN);
    assign complete = accept && ((lane_q == LW'(PACK - 1)) || bus.i_last);

    // Current group with the incoming beat dropped into its lane; lanes
    // not yet written stay zero because pack_q is cleared per group.
    for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
        assign merged[gi*DW +: DW] = (accept && (lane_q == LW'(gi)))
                                     ? bus.i_data : pack_q[gi*DW +: DW];
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        pack_d  = pack_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        waddr_d = waddr_q;
        bank_d  = bank_q;
        cs_d    = '0;
        done_d  = 1'b0;
        err_d   = err_q;
        full_d  = full_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d = ST_RUN;
                    waddr_d = bus.i_base;
                    lane_d  = '0;
                    bank_d  = '0;
                    pack_d  = '0;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (complete) begin
                        pack_d = '0;
                        lane_d = '0;
                        // Once the last address of the last bank is used,
                        // every further write is dropped and flagged.
                        if (full_q) begin
                            err_d = 1'b1;
                        end else begin
                            cs_d    = NBANK'(1) << bank_q;
                            addr_d  = waddr_q;
                            wdata_d = merged;
                            bank_d  = bank_q + 1'b1;
                            if (bank_q == {BW{1'b1}}) begin
                                waddr_d = waddr_q + 1'b1;
                                if (waddr_q == {AW{1'b1}}) begin
                                    full_d = 1'b1;
                                end
                            end
                        end
                    end else begin
                        pack_d = merged;
                        lane_d = lane_q + 1'b1;
                    end
                    if (bus.i_last) begin
                        state_d = ST_DRAIN;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
            pack_q  <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            waddr_q <= '0;
            bank_q  <= '0;
            cs_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            pack_q  <= pack_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            bank_q  <= bank_d;
            cs_q    <= cs_d;
            done_q  <= done_d;
            err_q   <= err_d;
            full_q  <= full_d;
        end
    end

    assign bus.o_rdy   = (state_q == ST_RUN);
    assign bus.o_busy  = (state_q != ST_IDLE);
    assign bus.o_wdata = wdata_q;
    assign bus.o_addr  = addr_q;
    assign bus.o_cs    = cs_q;
    assign bus.o_done  = done_q;
    assign bus.o_err   = err_q;
endmodule
